// File: rtl/accumulator_ctrl_if.sv
// Port bundle for accumulator_ctrl: job control, column capture bus and row output stream.
// The design drives through the slave modport and the array/consumer side uses master.
interface accumulator_ctrl_if #(
  parameter int unsigned NUM_COLS = 2,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ROWS_W   = 4
);
  logic                       start;
  logic [ROWS_W-1:0]          num_rows;
  logic [NUM_COLS-1:0]        col_valid;
  logic [NUM_COLS*DATA_W-1:0] col_data;
  logic                       stall;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_COLS*DATA_W-1:0] out_row;
  logic [ROWS_W-1:0]          out_row_idx;
  logic                       busy;
  logic                       done;
  logic                       overflow_err;

  modport master (
    output start, num_rows, col_valid, col_data, out_ready,
    input  stall, out_valid, out_row, out_row_idx, busy, done, overflow_err
  );

  modport slave (
    input  start, num_rows, col_valid, col_data, out_ready,
    output stall, out_valid, out_row, out_row_idx, busy, done, overflow_err
  );
endinterface

// File: rtl/accumulator_ctrl.sv
// Accumulator-stage sequencer: assembles per-column results into rows, queues them in a
// small row FIFO, drains them over valid/ready and signals job completion.
module accumulator_ctrl #(
  parameter int unsigned NUM_COLS = 2,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ROWS_W   = 4
) (
  input logic               clk,
  input logic               reset,
  accumulator_ctrl_if.slave bus
);

  localparam int unsigned ROW_W = NUM_COLS * DATA_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]                     state_q;
  logic [ROWS_W-1:0]              num_rows_q;
  logic [ROWS_W-1:0]              rows_in_q;
  logic [ROWS_W-1:0]              rows_out_q;
  logic [PTR_W-1:0]               wr_ptr_q;
  logic [PTR_W-1:0]               rd_ptr_q;
  logic [CNT_W-1:0]               count_q;
  logic [NUM_COLS-1:0][DATA_W-1:0] stage_q;
  logic [NUM_COLS-1:0]            captured_q;
  logic                           overflow_q;
  logic [ROW_W-1:0]               mem_q [DEPTH];

  logic [NUM_COLS-1:0] accept;
  logic [ROW_W-1:0]    merged_row;
  logic                fifo_full;
  logic                fifo_empty;
  logic                row_complete;
  logic                push;
  logic                pop;
  logic                dup_err;
  logic                drain_err;
  logic [ROWS_W-1:0]   rows_in_inc;

  // A column is only taken if its slot is still free; a completed row waiting on a
  // full FIFO keeps every slot occupied, so any strobe then counts as a duplicate.
  always_comb begin
    accept     = bus.col_valid & ~captured_q;
    merged_row = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      merged_row[c*DATA_W +: DATA_W] = accept[c] ? bus.col_data[c*DATA_W +: DATA_W] : stage_q[c];
    end
  end

  assign fifo_full    = (count_q == FULL_CNT);
  assign fifo_empty   = (count_q == '0);
  assign row_complete = &(captured_q | accept);
  assign push         = (state_q == COLLECT) && row_complete && !fifo_full;
  assign pop          = !fifo_empty && bus.out_ready;
  assign dup_err      = (state_q == COLLECT) && |(bus.col_valid & captured_q);
  assign drain_err    = (state_q == DRAIN) && |bus.col_valid;
  assign rows_in_inc  = rows_in_q + ROWS_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      num_rows_q <= '0;
      rows_in_q  <= '0;
      rows_out_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stage_q    <= '0;
      captured_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            num_rows_q <= bus.num_rows;
            overflow_q <= 1'b0;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            captured_q <= '0;
            state_q    <= (bus.num_rows == '0) ? DONE : COLLECT;
          end
        end
        COLLECT: begin
          for (int c = 0; c < NUM_COLS; c++) begin
            if (accept[c]) begin
              stage_q[c] <= bus.col_data[c*DATA_W +: DATA_W];
            end
          end
          if (push) begin
            captured_q <= '0;
            rows_in_q  <= rows_in_inc;
            if (rows_in_inc == num_rows_q) begin
              state_q <= DRAIN;
            end
          end else begin
            captured_q <= captured_q | accept;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (dup_err || drain_err) begin
        overflow_q <= 1'b1;
      end

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        rows_out_q <= rows_out_q + ROWS_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Row storage carries no reset; out_row is gated so reset still yields all-zero outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= merged_row;
    end
  end

  assign bus.stall        = fifo_full;
  assign bus.out_valid    = !fifo_empty;
  assign bus.out_row      = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign bus.out_row_idx  = rows_out_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_accumulator_ctrl.sv
// Bench for accumulator_ctrl: directed scenarios plus random jobs, each cycle compared
// against a queue-based model of the row FIFO, staging slots and error flag.
module tb_accumulator_ctrl;
  localparam int unsigned NUM_COLS = 2;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ROWS_W   = 4;
  localparam int unsigned ROW_W    = NUM_COLS * DATA_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  accumulator_ctrl_if #(.NUM_COLS(NUM_COLS), .DATA_W(DATA_W), .ROWS_W(ROWS_W)) bus ();

  accumulator_ctrl #(
    .NUM_COLS(NUM_COLS),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .ROWS_W  (ROWS_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // Reference model: queued rows, popped count, per-column slots, sticky error.
  logic [ROW_W-1:0]    m_q[$];
  int                  m_popped;
  bit                  m_err;
  bit                  m_collect;
  int                  m_num;
  int                  m_rows_in;
  bit [NUM_COLS-1:0]   m_have;
  logic [DATA_W-1:0]   m_val [NUM_COLS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    chk("stall", 32'(bus.stall), 32'(m_q.size() == DEPTH));
    if (m_q.size() != 0) chk("out_row", 32'(bus.out_row), 32'(m_q[0]));
    chk("out_row_idx", 32'(bus.out_row_idx), 32'(m_popped));
    chk("overflow_err", 32'(bus.overflow_err), 32'(m_err));
  endtask

  task automatic check_all_zero();
    chk("z_out_valid", 32'(bus.out_valid), 0);
    chk("z_stall", 32'(bus.stall), 0);
    chk("z_out_row", 32'(bus.out_row), 0);
    chk("z_idx", 32'(bus.out_row_idx), 0);
    chk("z_busy", 32'(bus.busy), 0);
    chk("z_done", 32'(bus.done), 0);
    chk("z_err", 32'(bus.overflow_err), 0);
  endtask

  // One clock: drive inputs, advance the model by the rules, then compare after the edge.
  task automatic cycle(input logic [NUM_COLS-1:0] cv, input logic [ROW_W-1:0] cd,
                       input logic ordy, input logic st);
    int               size0;
    bit               do_pop;
    logic [ROW_W-1:0] row;
    bus.col_valid = cv;
    bus.col_data  = cd;
    bus.out_ready = ordy;
    bus.start     = st;
    size0  = m_q.size();
    do_pop = (size0 != 0) && ordy;
    if (m_collect) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (cv[c]) begin
          if (m_have[c]) m_err = 1'b1;
          else begin
            m_have[c] = 1'b1;
            m_val[c]  = cd[c*DATA_W +: DATA_W];
          end
        end
      end
      if (&m_have && size0 < DEPTH) begin
        for (int c = 0; c < NUM_COLS; c++) row[c*DATA_W +: DATA_W] = m_val[c];
        m_q.push_back(row);
        m_have = '0;
        m_rows_in++;
        if (m_rows_in == m_num) m_collect = 1'b0;
      end
    end else if (size0 != 0 && cv != '0) begin
      m_err = 1'b1;
    end
    if (do_pop) begin
      void'(m_q.pop_front());
      m_popped++;
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic start_job(input int n);
    bus.start     = 1'b1;
    bus.num_rows  = ROWS_W'(n);
    bus.col_valid = '0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    m_err = 1'b0; m_popped = 0; m_rows_in = 0; m_num = n;
    m_collect = (n != 0); m_have = '0;
    check_model();
    chk("start_busy", 32'(bus.busy), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.col_valid = '0; bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero();
    reset = 1'b0;
    m_q.delete(); m_popped = 0; m_err = 1'b0; m_collect = 1'b0;
    m_have = '0; m_rows_in = 0;
  endtask

  // Drain with out_ready high, expect exactly one done pulse and busy low right after it.
  task automatic finish_job();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cycle('0, '0, 1'b1, 1'b0);
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 1);
    chk("queue_empty_at_done", 32'(m_q.size()), 0);
    cycle('0, '0, 1'b1, 1'b0);
    chk("done_single", 32'(bus.done), 0);
    chk("busy_after_done", 32'(bus.busy), 0);
    cycle('0, '0, 1'b1, 1'b0);
    chk("done_stays_low", 32'(bus.done), 0);
  endtask

  task automatic run_random_job(input int n);
    logic [NUM_COLS-1:0] cv;
    start_job(n);
    for (int i = 0; i < 400 && m_collect; i++) begin
      cv = '0;
      if (!(&m_have)) begin
        for (int c = 0; c < NUM_COLS; c++)
          if (!m_have[c] && $urandom_range(1, 0) == 1) cv[c] = 1'b1;
      end
      cycle(cv, ROW_W'($urandom), $urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0);
    end
    chk("rand_collect_end", 32'(m_collect), 0);
    finish_job();
  endtask

  initial begin
    int next_k;
    reset = 1'b0;
    bus.start = 1'b0; bus.num_rows = '0; bus.col_valid = '0;
    bus.col_data = '0; bus.out_ready = 1'b0;
    @(posedge clk);
    phase = "reset";
    do_reset();

    phase = "basic";
    start_job(2);
    cycle(2'b01, 16'h0003, 1'b1, 1'b0);
    cycle(2'b10, 16'h0500, 1'b1, 1'b0);
    chk("row0", 32'(bus.out_row), 32'h0503);
    chk("idx0", 32'(bus.out_row_idx), 0);
    cycle(2'b11, 16'h0907, 1'b1, 1'b0);
    chk("row1", 32'(bus.out_row), 32'h0907);
    chk("idx1", 32'(bus.out_row_idx), 1);
    finish_job();

    phase = "backpressure";
    start_job(6);
    for (int k = 0; k < 5; k++) cycle(2'b11, 16'h1020 + 16'(k * 16'h0101), 1'b0, 1'b0);
    chk("bp_stall", 32'(bus.stall), 1);
    chk("bp_head", 32'(bus.out_row), 32'h1020);
    chk("bp_err", 32'(bus.overflow_err), 0);
    next_k = 5;
    for (int i = 0; i < 40 && m_collect; i++) begin
      if (m_have == '0 && next_k < 6) begin
        cycle(2'b11, 16'h1020 + 16'(next_k * 16'h0101), 1'b1, 1'b0);
        next_k++;
      end else begin
        cycle('0, '0, 1'b1, 1'b0);
      end
    end
    finish_job();

    phase = "protocol";
    bus.num_rows = 4'd5;
    start_job(1);
    cycle(2'b01, 16'h0011, 1'b0, 1'b0);
    cycle(2'b01, 16'h0022, 1'b0, 1'b0);
    chk("dup_err", 32'(bus.overflow_err), 1);
    cycle(2'b10, 16'h3300, 1'b0, 1'b0);
    chk("dup_row", 32'(bus.out_row), 32'h3311);
    bus.num_rows = 4'd5;
    cycle('0, '0, 1'b0, 1'b1);
    chk("ign_start_busy", 32'(bus.busy), 1);
    chk("ign_start_err", 32'(bus.overflow_err), 1);
    finish_job();
    chk("err_sticky", 32'(bus.overflow_err), 1);

    phase = "zero_rows";
    start_job(0);
    chk("zero_done", 32'(bus.done), 1);
    chk("zero_err_cleared", 32'(bus.overflow_err), 0);
    cycle('0, '0, 1'b1, 1'b0);
    chk("zero_done_low", 32'(bus.done), 0);
    chk("zero_busy_low", 32'(bus.busy), 0);

    phase = "drain_err";
    start_job(1);
    cycle(2'b11, 16'hABCD, 1'b0, 1'b0);
    cycle(2'b01, 16'h00EE, 1'b0, 1'b0);
    chk("drain_err", 32'(bus.overflow_err), 1);
    finish_job();

    phase = "reset_mid";
    start_job(3);
    cycle(2'b11, 16'h0102, 1'b0, 1'b0);
    cycle(2'b11, 16'h0304, 1'b0, 1'b0);
    cycle(2'b01, 16'h0005, 1'b0, 1'b0);
    do_reset();
    start_job(1);
    cycle(2'b11, 16'h7788, 1'b0, 1'b0);
    chk("post_reset_row", 32'(bus.out_row), 32'h7788);
    chk("post_reset_idx", 32'(bus.out_row_idx), 0);
    finish_job();

    phase = "random";
    for (int j = 0; j < 5; j++) run_random_job(int'($urandom_range(12, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/accumulator_ctrl.md
Name: accumulator_ctrl

Overview:
- Sequencer for the accumulator stage behind the systolic array.
- Collects per-column results into complete product rows and commits each row into a small row FIFO.
- Drains rows downstream over a valid/ready handshake, back-pressures the array when the FIFO is full, and reports job completion.
- A job is started by a `start` pulse carrying the number of rows to collect.

Parameters:
- NUM_COLS, 2, number of array columns, i.e. elements per row
- DATA_W, 8, bits per element
- DEPTH, 4, row FIFO entries (power of two, at least 2)
- ROWS_W, 4, width of row count and row index

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle job start; honoured only in IDLE
- num_rows  in  ROWS_W  rows in the job; latched on an accepted start
- col_valid  in  NUM_COLS  per-column result strobe
- col_data  in  NUM_COLS*DATA_W  column c occupies bits [c*DATA_W +: DATA_W]
- stall  out  1  FIFO full; the array must hold its outputs
- out_valid  out  1  a committed row is available
- out_ready  in  1  downstream accepts the row
- out_row  out  NUM_COLS*DATA_W  head-of-FIFO row, same packing as col_data
- out_row_idx  out  ROWS_W  job-relative index of the head row (0-based)
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse on job completion
- overflow_err  out  1  sticky protocol error; cleared only by reset or an accepted start

Behaviour:
- Reset (synchronous, active-high) takes effect at the next rising edge and overrides every other input.
  - State becomes IDLE; FIFO pointers, count, staging register, captured mask and all counters clear.
  - Every output is 0.
  - Reset mid-job discards all staged and queued rows.
- States: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - col_valid and out_ready are ignored.
  - start latches num_rows, clears overflow_err and the row counters, then moves to COLLECT.
  - If num_rows == 0, it moves to DONE instead.
- COLLECT, column capture:
  - A staging register holds NUM_COLS elements; a captured mask holds one bit per column.
  - When col_valid[c] is high and captured[c] is 0, the element is stored and captured[c] is set.
  - When col_valid[c] is high and captured[c] is already 1, the value is dropped and overflow_err is set.
  - Columns may arrive in any order, across any number of cycles, or all in one cycle.
- COLLECT, row commit:
  - Commit happens at the edge where (captured | accepted col_valid) becomes all ones and count < DEPTH.
  - Committed row = staged elements merged with the same-cycle inputs.
  - On commit the row is pushed to the FIFO, the captured mask clears and rows_in increments.
  - If the FIFO is full, the completed row waits in staging. While waiting, further col_valid on any column sets overflow_err and the value is dropped.
- COLLECT, exit: when rows_in reaches the latched num_rows, the state moves to DRAIN on the same edge as the final commit.
- stall = (count == DEPTH). It is a combinational function of the registered count and is independent of out_ready in the same cycle.
- FIFO and output handshake:
  - out_valid = (count != 0); out_row is the head entry.
  - A pop occurs on an edge where out_valid && out_ready. Each pop increments rows_out, and out_row_idx = rows_out.
  - Push and pop on the same edge leave count unchanged.
  - A push is never accepted while count == DEPTH, even if a pop occurs on the same edge.
  - Latency: a row completed at edge t is visible on out_valid in the cycle after t. A full FIFO stays stalled for at least one cycle after a pop.
  - out_row must hold stable while out_valid is high and out_ready is low.
- DRAIN:
  - col_valid is ignored; any col_valid bit set to 1 sets overflow_err.
  - When count reaches 0, the state moves to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. busy is high in COLLECT, DRAIN and DONE.
- start outside IDLE is ignored and does not raise an error.
- Counters are ROWS_W wide and do not wrap within a job, since num_rows is at most 2^ROWS_W - 1.

Test Plan:
- Basic job: num_rows = 2, NUM_COLS = 2, out_ready held at 1.
  - Stimulus: col0 = 0x03 at cycle 1, col1 = 0x05 at cycle 2, then both columns {0x07, 0x09} at cycle 3.
  - Required: out_row 0x0503 with idx 0, then 0x0907 with idx 1, each one cycle after its completing edge.
  - done pulses once; busy falls the next cycle.
- Backpressure: out_ready = 0, DEPTH = 4, num_rows = 6, one full row per cycle.
  - Required: stall = 1 after 4 commits; the 5th row waits in staging.
  - Raising out_ready drains rows in order with idx 0..5, with no loss and no duplicates.
- Protocol error: col0 strobed twice (0x11 then 0x22) before col1 = 0x33.
  - Required: overflow_err = 1, and the committed row = 0x3311.
  - The flag stays set until the next accepted start.
- num_rows = 0: start leads to DONE in the next cycle; done pulses for one cycle; out_valid never rises.
- Reset mid-operation: assert reset while the FIFO holds 2 rows and 1 column is staged.
  - Required: all outputs are 0 at the next edge.
  - A new job with num_rows = 1 then completes normally with idx 0.
- Ignored start: start pulses during DRAIN.
  - Required: no state change, num_rows is not re-latched, and overflow_err is unchanged.
